// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between key-tagged requesters.
// Results are broadcast to every requester and release the slot whose issued key matches.
`ifndef KEY_SIZE
`define KEY_SIZE 8
`endif
`ifndef OPCODE_SIZE
`define OPCODE_SIZE 4
`endif
`ifndef OPERAND_SIZE
`define OPERAND_SIZE 16
`endif

module alu_arbiter #(
  parameter int n_req        = 2,
  parameter int key_size     = `KEY_SIZE,
  parameter int opcode_size  = `OPCODE_SIZE,
  parameter int operand_size = `OPERAND_SIZE,
  parameter int timeout      = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            en,
  input  logic [n_req*key_size-1:0]       req_key_i,
  input  logic [n_req*opcode_size-1:0]    req_op_i,
  input  logic [n_req*operand_size-1:0]   req_A_i,
  input  logic [n_req*operand_size-1:0]   req_B_i,
  output logic [key_size-1:0]             alu_key_o,
  output logic [opcode_size-1:0]          alu_op_o,
  output logic [operand_size-1:0]         alu_A_o,
  output logic [operand_size-1:0]         alu_B_o,
  input  logic [key_size-1:0]             alu_key_i,
  input  logic [operand_size-1:0]         alu_O_i,
  output logic [key_size-1:0]             res_key_o,
  output logic [operand_size-1:0]         res_O_o,
  output logic [n_req-1:0]                busy_o,
  output logic [n_req-1:0]                timeout_o
);

  localparam int pw = (n_req > 1) ? $clog2(n_req) : 1;
  localparam int tw = (timeout > 0) ? $clog2(timeout + 1) : 1;
  localparam logic [pw-1:0] last_idx = pw'(n_req - 1);
  localparam logic [tw-1:0] t_max    = tw'(timeout);
  localparam logic [tw-1:0] t_last   = tw'(timeout - 1);

  logic [key_size-1:0]     key_a [n_req];
  logic [opcode_size-1:0]  op_a  [n_req];
  logic [operand_size-1:0] a_a   [n_req];
  logic [operand_size-1:0] b_a   [n_req];

  logic [n_req-1:0]        busy;
  logic [n_req-1:0]        tout;
  logic [key_size-1:0]     issued_key [n_req];
  logic [tw-1:0]           timer      [n_req];
  logic [pw-1:0]           ptr;

  logic [n_req-1:0]        eligible;
  logic                    grant_valid;
  logic [pw-1:0]           grant_idx;

  // Requester 0 sits in the most-significant slice of every packed bus and status vector.
  always_comb begin
    for (int i = 0; i < n_req; i++) begin
      key_a[i]    = req_key_i[(n_req-1-i)*key_size +: key_size];
      op_a[i]     = req_op_i[(n_req-1-i)*opcode_size +: opcode_size];
      a_a[i]      = req_A_i[(n_req-1-i)*operand_size +: operand_size];
      b_a[i]      = req_B_i[(n_req-1-i)*operand_size +: operand_size];
      eligible[i] = (key_a[i] != '0) && !busy[i];
      busy_o[n_req-1-i]    = busy[i];
      timeout_o[n_req-1-i] = tout[i];
    end
  end

  always_comb begin
    int c;
    grant_valid = 1'b0;
    grant_idx   = '0;
    c           = 0;
    for (int k = 0; k < n_req; k++) begin
      c = int'(ptr) + k;
      if (c >= n_req) c = c - n_req;
      if (en && !grant_valid && eligible[c]) begin
        grant_valid = 1'b1;
        grant_idx   = pw'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_key_o <= '0;
      alu_op_o  <= '0;
      alu_A_o   <= '0;
      alu_B_o   <= '0;
      res_key_o <= '0;
      res_O_o   <= '0;
      busy      <= '0;
      tout      <= '0;
      ptr       <= '0;
      for (int i = 0; i < n_req; i++) begin
        issued_key[i] <= '0;
        timer[i]      <= '0;
      end
    end else if (clr) begin
      alu_key_o <= '0;
      alu_op_o  <= '0;
      alu_A_o   <= '0;
      alu_B_o   <= '0;
      res_key_o <= '0;
      res_O_o   <= '0;
      busy      <= '0;
      tout      <= '0;
      ptr       <= '0;
      for (int i = 0; i < n_req; i++) begin
        issued_key[i] <= '0;
        timer[i]      <= '0;
      end
    end else begin
      res_key_o <= alu_key_i;
      res_O_o   <= alu_O_i;
      alu_key_o <= '0;
      if (grant_valid) begin
        alu_key_o <= key_a[grant_idx];
        alu_op_o  <= op_a[grant_idx];
        alu_A_o   <= a_a[grant_idx];
        alu_B_o   <= b_a[grant_idx];
        ptr       <= (grant_idx == last_idx) ? '0 : grant_idx + 1'b1;
      end
      // A matching result wins over a timeout landing in the same cycle.
      for (int i = 0; i < n_req; i++) begin
        if (busy[i]) begin
          if (alu_key_i != '0 && alu_key_i == issued_key[i]) begin
            busy[i] <= 1'b0;
          end else if (timer[i] == t_last) begin
            busy[i] <= 1'b0;
            tout[i] <= 1'b1;
          end
          if (timer[i] != t_max) timer[i] <= timer[i] + 1'b1;
        end
        // Only idle slots are eligible, so a grant never collides with a release.
        if (grant_valid && grant_idx == pw'(i)) begin
          busy[i]       <= 1'b1;
          issued_key[i] <= key_a[i];
          timer[i]      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: issue, round-robin contention, release/grant overlap,
// reset and clear, timeout and enable gating, all against hand-computed expectations.
module tb_alu_arbiter;
  localparam int NR = 2;
  localparam int KW = 8;
  localparam int OW = 4;
  localparam int DW = 16;
  localparam int TO = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic              en;
  logic [NR*KW-1:0]  req_key;
  logic [NR*OW-1:0]  req_op;
  logic [NR*DW-1:0]  req_a;
  logic [NR*DW-1:0]  req_b;
  logic [KW-1:0]     alu_key;
  logic [OW-1:0]     alu_op;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [KW-1:0]     alu_key_in;
  logic [DW-1:0]     alu_o_in;
  logic [KW-1:0]     res_key;
  logic [DW-1:0]     res_o;
  logic [NR-1:0]     busy;
  logic [NR-1:0]     tout;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(
    .n_req(NR), .key_size(KW), .opcode_size(OW), .operand_size(DW), .timeout(TO)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en),
    .req_key_i(req_key), .req_op_i(req_op), .req_A_i(req_a), .req_B_i(req_b),
    .alu_key_o(alu_key), .alu_op_o(alu_op), .alu_A_o(alu_a), .alu_B_o(alu_b),
    .alu_key_i(alu_key_in), .alu_O_i(alu_o_in),
    .res_key_o(res_key), .res_O_o(res_o),
    .busy_o(busy), .timeout_o(tout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " alu_key"}, 32'(alu_key), 32'h0);
    check({tag, " alu_op"},  32'(alu_op),  32'h0);
    check({tag, " alu_a"},   32'(alu_a),   32'h0);
    check({tag, " alu_b"},   32'(alu_b),   32'h0);
    check({tag, " res_key"}, 32'(res_key), 32'h0);
    check({tag, " res_o"},   32'(res_o),   32'h0);
    check({tag, " busy"},    32'(busy),    32'h0);
    check({tag, " tout"},    32'(tout),    32'h0);
  endtask

  task automatic do_clr();
    req_key    = '0;
    alu_key_in = '0;
    clr        = 1'b1;
    step();
    clr        = 1'b0;
  endtask

  initial begin
    logic [KW-1:0] exp_k;
    rst = 1'b0; clr = 1'b0; en = 1'b0;
    req_key = '0; req_op = '0; req_a = '0; req_b = '0;
    alu_key_in = '0; alu_o_in = '0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b1;
    step();

    // Single request from requester 1, ALU answers three cycles after issue.
    en      = 1'b1;
    req_key = {8'h00, 8'h21};
    req_op  = {4'h0, 4'h1};
    req_a   = {16'd0, 16'd5};
    req_b   = {16'd0, 16'd7};
    step();
    check("single alu_key", 32'(alu_key), 32'h21);
    check("single alu_op",  32'(alu_op),  32'h1);
    check("single alu_a",   32'(alu_a),   32'd5);
    check("single alu_b",   32'(alu_b),   32'd7);
    check("single busy",    32'(busy),    32'b01);
    step();
    check("single no reissue", 32'(alu_key), 32'h0);
    check("single busy held",  32'(busy),    32'b01);
    step();
    check("single busy held2", 32'(busy), 32'b01);
    alu_key_in = 8'h21;
    alu_o_in   = 16'd12;
    req_key    = '0;
    step();
    check("single res_key", 32'(res_key), 32'h21);
    check("single res_o",   32'(res_o),   32'd12);
    check("single release", 32'(busy),    32'b00);
    alu_key_in = '0;
    step();
    check("single res clear", 32'(res_key), 32'h0);

    // Continuous contention, ALU echoes each issue one cycle later.
    req_key = {8'h11, 8'h22};
    for (int c = 0; c < 6; c++) begin
      step();
      exp_k = (c % 2 == 0) ? 8'h11 : 8'h22;
      check("rr alu_key", 32'(alu_key), 32'(exp_k));
      check("rr busy",    32'(busy),    (c % 2 == 0) ? 32'b10 : 32'b01);
      if (c > 0) check("rr res_key", 32'(res_key), (c % 2 == 0) ? 32'h22 : 32'h11);
      alu_key_in = alu_key;
      alu_o_in   = 16'(c);
    end
    do_clr();
    check_all_zero("clr");

    // Release of requester 0 coincides with requester 1 becoming eligible.
    req_key = {8'h31, 8'h00};
    step();
    check("overlap grant0", 32'(alu_key), 32'h31);
    check("overlap busy10", 32'(busy),    32'b10);
    alu_key_in = 8'h31;
    req_key    = {8'h31, 8'h42};
    step();
    check("overlap grant1", 32'(alu_key), 32'h42);
    check("overlap busy01", 32'(busy),    32'b01);
    check("overlap res",    32'(res_key), 32'h31);
    alu_key_in = '0;
    step();
    check("overlap regrant0", 32'(alu_key), 32'h31);
    check("overlap busy11",   32'(busy),    32'b11);

    // Asynchronous reset with both slots in flight.
    #2 rst = 1'b0;
    #1;
    check_all_zero("async reset");
    step();
    rst = 1'b1;
    step();
    check("post reset grant0", 32'(alu_key), 32'h31);
    check("post reset busy",   32'(busy),    32'b10);
    do_clr();

    // Timeout of requester 0 with no result.
    req_key = {8'h55, 8'h00};
    step();
    check("tmo issue", 32'(alu_key), 32'h55);
    for (int k = 1; k < TO; k++) begin
      step();
      check("tmo busy held", 32'(busy),    32'b10);
      check("tmo no reissue", 32'(alu_key), 32'h0);
    end
    check("tmo flag early", 32'(tout), 32'b00);
    req_key = '0;
    step();
    check("tmo release", 32'(busy), 32'b00);
    check("tmo flag",    32'(tout), 32'b10);
    alu_key_in = 8'h55;
    alu_o_in   = 16'h99;
    step();
    check("late res_key", 32'(res_key), 32'h55);
    check("late res_o",   32'(res_o),   32'h99);
    check("late busy",    32'(busy),    32'b00);
    check("late flag",    32'(tout),    32'b10);
    alu_key_in = '0;
    step();
    check("tmo sticky", 32'(tout), 32'b10);
    do_clr();
    check("clr tout", 32'(tout), 32'b00);

    // Enable gating with both requests pending.
    en      = 1'b0;
    req_key = {8'h11, 8'h22};
    for (int k = 0; k < 3; k++) begin
      step();
      check("en0 alu_key", 32'(alu_key), 32'h0);
      check("en0 busy",    32'(busy),    32'b00);
    end
    en = 1'b1;
    step();
    check("en1 first", 32'(alu_key), 32'h11);
    check("en1 busy",  32'(busy),    32'b10);
    step();
    check("en1 second", 32'(alu_key), 32'h22);
    check("en1 busy2",  32'(busy),    32'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
